// File: rtl/fib_tx_arb.sv
// fib_tx_arb: two-channel whole-frame arbiter in the clk_fib domain.
//
// Sits between two write-FIFO pairs (64-bit data FIFO + 32-bit byte-count
// FIFO, both show-ahead) and the single TX frame sender feeding the FMAC.
// One frame at a time is granted. The granted pair is muxed onto the
// sender-facing FIFO interface and the other pair is hidden. The grant is
// released exactly at end-of-frame, using the word count derived from the
// frame's byte count.
//
// Ports:
//   clk_fib, reset_              clock, asynchronous active-low reset
//   rdempty_wf0/1, rdempty_wcf0/1  per-channel data / count FIFO empties
//   dataout_wf0/1, dataout_wcf0/1  per-channel show-ahead FIFO outputs
//   rden_wf0/1, rden_wcf0/1        per-channel FIFO pops (granted channel only)
//   fib_mac_usedw                FMAC TX FIFO fill level (gates new grants)
//   rden_wf, rden_wcf            pops issued by the sender
//   rdempty_wf, rdempty_wcf      empties presented to the sender
//   dataout_wf, dataout_wcf      muxed FIFO data presented to the sender
//   gnt                          one-hot current grant
//   frm_cnt0, frm_cnt1           completed-frame counters (wrap at FFFF)
//   err_stray                    sticky flag for pops outside a legal window
//
// Build option: define FIB_TX_ARB_STRICT_PRIO_EN to make channel 0 win
// whenever it requests. The default build uses round-robin.

module fib_tx_arb #(
  parameter int          DATA_WIDTH   = 64,
  parameter int          BCNT_WIDTH   = 32,
  parameter logic [12:0] USEDW_THRESH = 13'h300
) (
  input  logic                  clk_fib,
  input  logic                  reset_,
  input  logic                  rdempty_wf0,
  input  logic                  rdempty_wcf0,
  input  logic [DATA_WIDTH-1:0] dataout_wf0,
  input  logic [BCNT_WIDTH-1:0] dataout_wcf0,
  output logic                  rden_wf0,
  output logic                  rden_wcf0,
  input  logic                  rdempty_wf1,
  input  logic                  rdempty_wcf1,
  input  logic [DATA_WIDTH-1:0] dataout_wf1,
  input  logic [BCNT_WIDTH-1:0] dataout_wcf1,
  output logic                  rden_wf1,
  output logic                  rden_wcf1,
  input  logic [12:0]           fib_mac_usedw,
  input  logic                  rden_wf,
  input  logic                  rden_wcf,
  output logic                  rdempty_wf,
  output logic                  rdempty_wcf,
  output logic [DATA_WIDTH-1:0] dataout_wf,
  output logic [BCNT_WIDTH-1:0] dataout_wcf,
  output logic [1:0]            gnt,
  output logic [15:0]           frm_cnt0,
  output logic [15:0]           frm_cnt1,
  output logic                  err_stray
);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_XFER  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  arb_state_t  state, state_next;
  logic [1:0]  gnt_next;
  logic        last, last_next;
  logic [13:0] remaining, remaining_next;
  logic [15:0] frm_cnt0_next, frm_cnt1_next;
  logic        err_next;

  logic        req0, req1, pick;
  logic        sel_rdempty_wf, sel_rdempty_wcf;
  logic        pop_wf, pop_wcf;
  logic [16:0] bcnt_sum;
  logic [13:0] words;

  assign req0 = !rdempty_wcf0 & !rdempty_wf0;
  assign req1 = !rdempty_wcf1 & !rdempty_wf1;

  // pick = 1 selects channel 1. Round-robin prefers the channel that was
  // not served last; a lone requester always wins.
`ifdef FIB_TX_ARB_STRICT_PRIO_EN
  assign pick = !req0;
`else
  assign pick = (req0 & req1) ? !last : req1;
`endif

  // Muxing is keyed off the registered grant so it never glitches with requests
  assign sel_rdempty_wf  = gnt[1] ? rdempty_wf1  : rdempty_wf0;
  assign sel_rdempty_wcf = gnt[1] ? rdempty_wcf1 : rdempty_wcf0;
  assign dataout_wf  = gnt[1] ? dataout_wf1  : (gnt[0] ? dataout_wf0  : '0);
  assign dataout_wcf = gnt[1] ? dataout_wcf1 : (gnt[0] ? dataout_wcf0 : '0);

  // Round the byte count up to whole 64-bit words; 17-bit sum avoids overflow at FFFF
  assign bcnt_sum = {1'b0, dataout_wcf[15:0]} + 17'd7;
  assign words    = 14'(bcnt_sum >> 3);

  assign rden_wcf0 = pop_wcf & gnt[0];
  assign rden_wcf1 = pop_wcf & gnt[1];
  assign rden_wf0  = pop_wf  & gnt[0];
  assign rden_wf1  = pop_wf  & gnt[1];

  // Next-state and sender-facing outputs. Empties default high so any pop
  // outside the one open window is both dropped and flagged.
  always_comb begin
    state_next     = state;
    gnt_next       = gnt;
    last_next      = last;
    remaining_next = remaining;
    frm_cnt0_next  = frm_cnt0;
    frm_cnt1_next  = frm_cnt1;
    rdempty_wf     = 1'b1;
    rdempty_wcf    = 1'b1;
    pop_wf         = 1'b0;
    pop_wcf        = 1'b0;

    case (state)
      ARB_IDLE: begin
        gnt_next = 2'b00;
        if ((req0 | req1) && (fib_mac_usedw <= USEDW_THRESH)) begin
          gnt_next   = pick ? 2'b10 : 2'b01;
          state_next = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        rdempty_wcf = sel_rdempty_wcf;
        pop_wcf     = rden_wcf & !sel_rdempty_wcf;
        if (pop_wcf) begin
          remaining_next = words;
          state_next     = (words != 14'd0) ? ARB_XFER : ARB_DONE;
        end
      end
      ARB_XFER: begin
        // A data FIFO underrun simply holds here until data arrives
        rdempty_wf = sel_rdempty_wf | (remaining == 14'd0);
        pop_wf     = rden_wf & !rdempty_wf;
        if (pop_wf) begin
          remaining_next = remaining - 14'd1;
          if (remaining == 14'd1) state_next = ARB_DONE;
        end
      end
      ARB_DONE: begin
        last_next = gnt[1];
        if (gnt[1]) frm_cnt1_next = frm_cnt1 + 16'd1;
        else        frm_cnt0_next = frm_cnt0 + 16'd1;
        gnt_next   = 2'b00;
        state_next = ARB_IDLE;
      end
      default: begin
        gnt_next   = 2'b00;
        state_next = ARB_IDLE;
      end
    endcase

    err_next = err_stray | (rden_wf & rdempty_wf) | (rden_wcf & rdempty_wcf);
  end

  // State register. last resets to channel 1 so channel 0 wins the first tie.
  always_ff @(posedge clk_fib or negedge reset_) begin
    if (!reset_) begin
      state     <= ARB_IDLE;
      gnt       <= 2'b00;
      last      <= 1'b1;
      remaining <= 14'd0;
      frm_cnt0  <= 16'd0;
      frm_cnt1  <= 16'd0;
      err_stray <= 1'b0;
    end else begin
      state     <= state_next;
      gnt       <= gnt_next;
      last      <= last_next;
      remaining <= remaining_next;
      frm_cnt0  <= frm_cnt0_next;
      frm_cnt1  <= frm_cnt1_next;
      err_stray <= err_next;
    end
  end

endmodule

// File: tb/tb_fib_tx_arb.sv
// tb_fib_tx_arb: self-checking bench for fib_tx_arb.
//
// Behavioural show-ahead FIFO models feed both channels. A sender model pops
// frames and compares each popped count/data word against a scoreboard queue
// filled in expected grant order when the frames are loaded. A table of
// reset-to-grant vectors covers request and fill-level combinations, and
// hand-written sequences cover frame timing, stray pops, zero-length frames,
// mid-frame reset and grant ordering (round-robin or strict priority,
// following FIB_TX_ARB_STRICT_PRIO_EN).

module tb_fib_tx_arb;

  logic        clk_fib = 1'b0;
  logic        reset_;
  logic        rdempty_wf0, rdempty_wcf0, rdempty_wf1, rdempty_wcf1;
  logic [63:0] dataout_wf0, dataout_wf1;
  logic [31:0] dataout_wcf0, dataout_wcf1;
  logic        rden_wf0, rden_wcf0, rden_wf1, rden_wcf1;
  logic [12:0] fib_mac_usedw;
  logic        rden_wf, rden_wcf;
  logic        rdempty_wf, rdempty_wcf;
  logic [63:0] dataout_wf;
  logic [31:0] dataout_wcf;
  logic [1:0]  gnt;
  logic [15:0] frm_cnt0, frm_cnt1;
  logic        err_stray;

  always #5 clk_fib = ~clk_fib;

  fib_tx_arb dut (
    .clk_fib(clk_fib), .reset_(reset_),
    .rdempty_wf0(rdempty_wf0), .rdempty_wcf0(rdempty_wcf0),
    .dataout_wf0(dataout_wf0), .dataout_wcf0(dataout_wcf0),
    .rden_wf0(rden_wf0), .rden_wcf0(rden_wcf0),
    .rdempty_wf1(rdempty_wf1), .rdempty_wcf1(rdempty_wcf1),
    .dataout_wf1(dataout_wf1), .dataout_wcf1(dataout_wcf1),
    .rden_wf1(rden_wf1), .rden_wcf1(rden_wcf1),
    .fib_mac_usedw(fib_mac_usedw),
    .rden_wf(rden_wf), .rden_wcf(rden_wcf),
    .rdempty_wf(rdempty_wf), .rdempty_wcf(rdempty_wcf),
    .dataout_wf(dataout_wf), .dataout_wcf(dataout_wcf),
    .gnt(gnt), .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1),
    .err_stray(err_stray)
  );

  logic [63:0] q_d0[$], q_d1[$];
  logic [31:0] q_c0[$], q_c1[$];
  logic [63:0] sb_data[$];
  logic [31:0] sb_cnt[$];
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [3:0]  fill;
    logic [12:0] usedw;
    logic [1:0]  exp_gnt;
  } vec_t;

  function automatic logic [63:0] word_val(input int ch, input int tag, input int i);
    return {16'hD000 + 16'(ch), 16'(tag), 32'(i)};
  endfunction

  function automatic logic [31:0] cnt_val(input int bcnt);
    return {16'hA5C3, 16'(bcnt)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic wf, input logic wcf);
    rden_wf  = wf;
    rden_wcf = wcf;
  endtask

  task automatic refresh_fifos();
    rdempty_wf0  = (q_d0.size() == 0);
    rdempty_wcf0 = (q_c0.size() == 0);
    rdempty_wf1  = (q_d1.size() == 0);
    rdempty_wcf1 = (q_c1.size() == 0);
    dataout_wf0  = (q_d0.size() != 0) ? q_d0[0] : 64'h0;
    dataout_wcf0 = (q_c0.size() != 0) ? q_c0[0] : 32'h0;
    dataout_wf1  = (q_d1.size() != 0) ? q_d1[0] : 64'h0;
    dataout_wcf1 = (q_c1.size() != 0) ? q_c1[0] : 32'h0;
  endtask

  // One clock: sample channel pops just before the edge, apply them to the
  // FIFO models just after it, then let the DUT settle.
  task automatic tick();
    logic p_d0, p_c0, p_d1, p_c1;
    #1;
    p_d0 = rden_wf0; p_c0 = rden_wcf0; p_d1 = rden_wf1; p_c1 = rden_wcf1;
    @(posedge clk_fib);
    #1;
    if (p_d0 && q_d0.size() != 0) void'(q_d0.pop_front());
    if (p_c0 && q_c0.size() != 0) void'(q_c0.pop_front());
    if (p_d1 && q_d1.size() != 0) void'(q_d1.pop_front());
    if (p_c1 && q_c1.size() != 0) void'(q_c1.pop_front());
    refresh_fifos();
    #1;
  endtask

  task automatic load_frame(input int ch, input int bcnt, input int nwords, input int tag);
    if (ch == 0) q_c0.push_back(cnt_val(bcnt));
    else         q_c1.push_back(cnt_val(bcnt));
    for (int i = 0; i < nwords; i++) begin
      if (ch == 0) q_d0.push_back(word_val(ch, tag, i));
      else         q_d1.push_back(word_val(ch, tag, i));
    end
  endtask

  task automatic sb_expect_frame(input int ch, input int bcnt, input int nwords, input int tag);
    sb_cnt.push_back(cnt_val(bcnt));
    for (int i = 0; i < nwords; i++) sb_data.push_back(word_val(ch, tag, i));
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    applyStimulus(1'b0, 1'b0);
    fib_mac_usedw = 13'h0;
    q_d0.delete(); q_d1.delete(); q_c0.delete(); q_c1.delete();
    sb_data.delete(); sb_cnt.delete();
    refresh_fifos();
    @(posedge clk_fib);
    @(posedge clk_fib);
    #1;
    reset_ = 1'b1;
    #1;
  endtask

  // Sender model: pops whatever is presented, checks it against the
  // scoreboard, and returns once the grant drops back to idle.
  task automatic serve_frame(input int budget);
    int  n = 0;
    bit  done = 0;
    while (!done && n < budget) begin
      applyStimulus(!rdempty_wf, !rdempty_wcf);
      if (rden_wcf) begin
        if (sb_cnt.size() == 0) checkOutput("sb_count_extra", 64'd1, 64'd0);
        else checkOutput("sb_count", 64'(dataout_wcf), 64'(sb_cnt.pop_front()));
      end
      if (rden_wf) begin
        if (sb_data.size() == 0) checkOutput("sb_data_extra", 64'd1, 64'd0);
        else checkOutput("sb_data", dataout_wf, sb_data.pop_front());
      end
      tick();
      n++;
      if (gnt == 2'b00) done = 1;
    end
    applyStimulus(1'b0, 1'b0);
    if (!done) checkOutput("serve_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_grant(input logic [1:0] exp, input int budget);
    int n = 0;
    while (gnt == 2'b00 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("grant_order", 64'(gnt), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int   order[5];
    int   tag0, tag1;

    vecs[0] = '{"both_over_thresh", 4'b1111, 13'h301, 2'b00};
    vecs[1] = '{"both_at_thresh",   4'b1111, 13'h300, 2'b01};
    vecs[2] = '{"both_usedw0",      4'b1111, 13'h000, 2'b01};
    vecs[3] = '{"ch1_only",         4'b0011, 13'h000, 2'b10};
    vecs[4] = '{"none",             4'b0000, 13'h000, 2'b00};
    vecs[5] = '{"ch1_count_only",   4'b0010, 13'h000, 2'b00};
    vecs[6] = '{"ch0_data_only",    4'b0100, 13'h000, 2'b00};
    vecs[7] = '{"ch1_over_thresh",  4'b0011, 13'h301, 2'b00};

    // Reset values while FIFOs are loaded and the sender is popping
    reset_ = 1'b0;
    fib_mac_usedw = 13'h0;
    q_d0.delete(); q_d1.delete(); q_c0.delete(); q_c1.delete();
    load_frame(0, 8, 1, 0);
    load_frame(1, 8, 1, 0);
    refresh_fifos();
    applyStimulus(1'b1, 1'b1);
    @(posedge clk_fib);
    #2;
    checkOutput("rst_gnt", 64'(gnt), 64'd0);
    checkOutput("rst_rdempty", 64'({rdempty_wf, rdempty_wcf}), 64'd3);
    checkOutput("rst_dataout", dataout_wf | 64'(dataout_wcf), 64'd0);
    checkOutput("rst_rden", 64'({rden_wf0, rden_wcf0, rden_wf1, rden_wcf1}), 64'd0);
    checkOutput("rst_cnt_err", 64'({frm_cnt0, frm_cnt1, err_stray}), 64'd0);

    // Table: request/fill-level combinations one cycle after reset
    for (int v = 0; v < 8; v++) begin
      do_reset();
      if (vecs[v].fill[3]) q_c0.push_back(cnt_val(8));
      if (vecs[v].fill[2]) q_d0.push_back(word_val(0, 1, 0));
      if (vecs[v].fill[1]) q_c1.push_back(cnt_val(8));
      if (vecs[v].fill[0]) q_d1.push_back(word_val(1, 1, 0));
      fib_mac_usedw = vecs[v].usedw;
      refresh_fifos();
      tick();
      checkOutput(vecs[v].name, 64'(gnt), 64'(vecs[v].exp_gnt));
      checkOutput({vecs[v].name, "_rdempty_wcf"}, 64'(rdempty_wcf),
                  64'(vecs[v].exp_gnt == 2'b00));
    end

    // Two 24-byte frames: ch0 first, exact end-of-frame timing, then ch1
    do_reset();
    load_frame(0, 24, 3, 1);
    load_frame(1, 24, 3, 2);
    sb_expect_frame(0, 24, 3, 1);
    sb_expect_frame(1, 24, 3, 2);
    refresh_fifos();
    tick();
    checkOutput("t1_gnt_ch0", 64'(gnt), 64'd1);
    checkOutput("t1_wcf_open", 64'(rdempty_wcf), 64'd0);
    checkOutput("t1_wf_closed", 64'(rdempty_wf), 64'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t1_count", 64'(dataout_wcf), 64'(sb_cnt.pop_front()));
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("t1_wf_open", 64'(rdempty_wf), 64'd0);
      checkOutput("t1_data", dataout_wf, sb_data.pop_front());
      tick();
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_done_gnt", 64'(gnt), 64'd1);
    checkOutput("t1_done_wf", 64'(rdempty_wf), 64'd1);
    checkOutput("t1_ch1_untouched", 64'(q_d1.size()), 64'd3);
    tick();
    checkOutput("t1_idle_gnt", 64'(gnt), 64'd0);
    tick();
    checkOutput("t1_gnt_ch1_m3", 64'(gnt), 64'd2);
    serve_frame(20);
    checkOutput("t1_frm_cnt0", 64'(frm_cnt0), 64'd1);
    checkOutput("t1_frm_cnt1", 64'(frm_cnt1), 64'd1);
    checkOutput("t1_err", 64'(err_stray), 64'd0);

    // 17-byte frame: 3 words; a 4th sender pop is dropped and flagged
    do_reset();
    load_frame(0, 17, 4, 3);
    refresh_fifos();
    tick();
    applyStimulus(1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("t2_wf_open", 64'(rdempty_wf), 64'd0);
      tick();
    end
    checkOutput("t2_err_before", 64'(err_stray), 64'd0);
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("t2_stray_not_fwd", 64'(rden_wf0), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t2_err_set", 64'(err_stray), 64'd1);
    checkOutput("t2_word_left", 64'(q_d0.size()), 64'd1);
    tick();
    tick();
    checkOutput("t2_err_sticky", 64'(err_stray), 64'd1);

    // Stray count pop while idle is dropped and flagged
    do_reset();
    q_c0.push_back(cnt_val(8));
    refresh_fifos();
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t2b_count_kept", 64'(q_c0.size()), 64'd1);
    checkOutput("t2b_err_set", 64'(err_stray), 64'd1);

    // Fill level gate: no grant above threshold, grant next cycle at it,
    // and the grant holds once taken whatever the fill level does
    do_reset();
    load_frame(0, 8, 1, 4);
    load_frame(1, 8, 1, 4);
    fib_mac_usedw = 13'h301;
    refresh_fifos();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t3_blocked", 64'(gnt), 64'd0);
    end
    fib_mac_usedw = 13'h300;
    tick();
    checkOutput("t3_granted", 64'(gnt), 64'd1);
    fib_mac_usedw = 13'h1FFF;
    tick();
    checkOutput("t3_grant_held", 64'(gnt), 64'd1);

    // Zero-byte frame on ch1: straight to done with no data pops
    do_reset();
    load_frame(1, 0, 1, 5);
    refresh_fifos();
    tick();
    checkOutput("t4_gnt_ch1", 64'(gnt), 64'd2);
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_done_wf", 64'(rdempty_wf), 64'd1);
    checkOutput("t4_done_gnt", 64'(gnt), 64'd2);
    checkOutput("t4_cnt_before", 64'(frm_cnt1), 64'd0);
    tick();
    checkOutput("t4_idle", 64'(gnt), 64'd0);
    checkOutput("t4_frm_cnt1", 64'(frm_cnt1), 64'd1);
    checkOutput("t4_data_kept", 64'(q_d1.size()), 64'd1);
    checkOutput("t4_err", 64'(err_stray), 64'd0);

    // Reset asserted mid-transfer with 5 words remaining
    do_reset();
    load_frame(0, 40, 5, 6);
    load_frame(0, 8, 1, 7);
    load_frame(1, 8, 1, 8);
    refresh_fifos();
    tick();
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("t5_xfer_fwd", 64'(rden_wf0), 64'd1);
    reset_ = 1'b0;
    #1;
    checkOutput("t5_rst_gnt", 64'(gnt), 64'd0);
    checkOutput("t5_rst_rdempty", 64'({rdempty_wf, rdempty_wcf}), 64'd3);
    checkOutput("t5_rst_dataout", dataout_wf | 64'(dataout_wcf), 64'd0);
    checkOutput("t5_rst_rden", 64'({rden_wf0, rden_wcf0, rden_wf1, rden_wcf1}), 64'd0);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk_fib);
    reset_ = 1'b1;
    checkOutput("t5_partial_left", 64'(q_d0.size()), 64'd6);
    tick();
    checkOutput("t5_regrant_ch0", 64'(gnt), 64'd1);

    // Grant order with ch0 holding 4 frames and ch1 one frame
    do_reset();
`ifdef FIB_TX_ARB_STRICT_PRIO_EN
    order = '{0, 0, 0, 0, 1};
`else
    order = '{0, 1, 0, 0, 0};
`endif
    for (int f = 0; f < 4; f++) load_frame(0, 8, 1, 10 + f);
    load_frame(1, 8, 1, 20);
    tag0 = 10;
    tag1 = 20;
    for (int k = 0; k < 5; k++) begin
      if (order[k] == 0) begin sb_expect_frame(0, 8, 1, tag0); tag0++; end
      else               begin sb_expect_frame(1, 8, 1, tag1); tag1++; end
    end
    refresh_fifos();
    for (int k = 0; k < 5; k++) begin
      wait_grant((order[k] == 0) ? 2'b01 : 2'b10, 10);
      serve_frame(20);
    end
    checkOutput("t6_frm_cnt0", 64'(frm_cnt0), 64'd4);
    checkOutput("t6_frm_cnt1", 64'(frm_cnt1), 64'd1);
    checkOutput("t6_sb_drained", 64'(sb_data.size() + sb_cnt.size()), 64'd0);
    checkOutput("t6_err", 64'(err_stray), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
